// File: rtl/pattern_gen_if.sv
// Stimulus/response bundle between pattern_gen (master) and its user (slave).
interface pattern_gen_if #(
  parameter int WIDTH = 4
) ();
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] pattern;
  logic             sample;
  logic             busy;
  logic             done;
  logic             dut_out;
  logic [7:0]       err_cnt;

  modport master (
    input  start, mode, dut_out,
    output pattern, sample, busy, done, err_cnt
  );

  modport slave (
    output start, mode, dut_out,
    input  pattern, sample, busy, done, err_cnt
  );
endinterface

// File: rtl/pattern_gen.sv
// Exhaustive binary/Gray/walking-one stimulus sweeper with per-pattern dwell.
// Optional OR-reduction response checker enabled by defining PATGEN_CHECK_EN.
module pattern_gen #(
  parameter int WIDTH = 4,
  parameter int DWELL = 50
) (
  input  logic          clk,
  input  logic          rst,
  pattern_gen_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [15:0]    DWELL_LAST = 16'(DWELL - 1);
  localparam logic [WIDTH:0] LAST_COUNT = (WIDTH + 1)'((1 << WIDTH) - 1);
  localparam logic [WIDTH:0] LAST_WALK  = (WIDTH + 1)'(WIDTH - 1);

  state_t           state, state_n;
  logic [1:0]       mode_r, mode_n;
  logic [WIDTH:0]   idx, idx_n;
  logic [15:0]      dwell, dwell_n;
  logic [WIDTH-1:0] pat;
  logic             hold_end;
  logic             last_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mode_r <= '0;
      idx    <= '0;
      dwell  <= '0;
    end else begin
      state  <= state_n;
      mode_r <= mode_n;
      idx    <= idx_n;
      dwell  <= dwell_n;
    end
  end

  // Pattern derives from index and latched mode, so it naturally holds its
  // final value through DONE and IDLE until the next accepted start.
  always_comb begin
    pat = idx[WIDTH-1:0];
    case (mode_r)
      2'b01:   pat = idx[WIDTH-1:0] ^ idx[WIDTH:1];
      2'b10:   pat = WIDTH'(1) << idx;
      default: pat = idx[WIDTH-1:0];
    endcase
  end

  assign hold_end = (state == RUN) && (dwell == DWELL_LAST);
  assign last_idx = (mode_r == 2'b10) ? (idx == LAST_WALK) : (idx == LAST_COUNT);

  always_comb begin
    state_n = state;
    mode_n  = mode_r;
    idx_n   = idx;
    dwell_n = dwell;
    case (state)
      IDLE: begin
        if (bus.start) begin
          mode_n  = bus.mode;
          idx_n   = '0;
          dwell_n = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        if (hold_end) begin
          dwell_n = '0;
          if (last_idx) state_n = DONE;
          else          idx_n   = idx + 1'b1;
        end else begin
          dwell_n = dwell + 16'd1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.pattern = pat;
  assign bus.sample  = hold_end;
  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);

`ifdef PATGEN_CHECK_EN
  logic [7:0] err, err_n;

  always_ff @(posedge clk) begin
    if (rst) err <= '0;
    else     err <= err_n;
  end

  always_comb begin
    err_n = err;
    if (state == IDLE && bus.start)
      err_n = '0;
    else if (hold_end && (bus.dut_out != (|pat)) && (err != '1))
      err_n = err + 8'd1;
  end

  assign bus.err_cnt = err;
`else
  assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_pattern_gen.sv
// Directed self-checking bench for pattern_gen: DWELL=3 and DWELL=1 instances.
module tb_pattern_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ideal = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;

  int bin_seq  [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
  int gray_seq [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
  int walk_seq [16] = '{1, 2, 4, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  always #5 clk = ~clk;

  pattern_gen_if #(.WIDTH(4)) bus3 ();
  pattern_gen_if #(.WIDTH(4)) bus1 ();

  pattern_gen #(.WIDTH(4), .DWELL(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.master));
  pattern_gen #(.WIDTH(4), .DWELL(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

  always_comb bus3.dut_out = ideal ? (|bus3.pattern) : 1'b0;
  always_comb bus1.dut_out = |bus1.pattern;

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    if (bus3.pattern !== 4'd0) begin n_mis++; $display("FAIL reset_pattern got %0h want 0", bus3.pattern); end
    n_cmp++;
    if (bus3.busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy got %b want 0", bus3.busy); end
    n_cmp++;
    if (bus3.done !== 1'b0) begin n_mis++; $display("FAIL reset_done got %b want 0", bus3.done); end
    n_cmp++;
    if (bus3.sample !== 1'b0) begin n_mis++; $display("FAIL reset_sample got %b want 0", bus3.sample); end
    n_cmp++;
    if (bus3.err_cnt !== 8'd0) begin n_mis++; $display("FAIL reset_err got %0d want 0", bus3.err_cnt); end
    n_cmp++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Full sweep on the DWELL=3 instance, checked every cycle against a table.
  task automatic sweep3(input logic [1:0] m, input int p, input int seq[16],
                        input bit stuck, input bit inject, input string name);
    logic [7:0] exp_err;
    logic [3:0] fin;
    exp_err = 8'd0;
`ifdef PATGEN_CHECK_EN
    if (stuck) exp_err = 8'd15;
`endif
    fin = 4'(seq[p-1]);
    ideal = !stuck;
    bus3.mode = m;
    bus3.start = 1'b1;
    @(negedge clk);
    bus3.start = 1'b0;
    if (bus3.err_cnt !== 8'd0) begin n_mis++; $display("FAIL %s err_clear got %0d want 0", name, bus3.err_cnt); end
    n_cmp++;
    for (int k = 0; k < p * 3; k++) begin
      if (bus3.pattern !== 4'(seq[k/3])) begin n_mis++; $display("FAIL %s pattern k=%0d got %0d want %0d", name, k, bus3.pattern, seq[k/3]); end
      n_cmp++;
      if (bus3.sample !== ((k % 3) == 2)) begin n_mis++; $display("FAIL %s sample k=%0d got %b want %b", name, k, bus3.sample, ((k % 3) == 2)); end
      n_cmp++;
      if (bus3.busy !== 1'b1) begin n_mis++; $display("FAIL %s busy k=%0d got %b want 1", name, k, bus3.busy); end
      n_cmp++;
      if (bus3.done !== 1'b0) begin n_mis++; $display("FAIL %s early_done k=%0d got %b want 0", name, k, bus3.done); end
      n_cmp++;
      if (inject && k == 4) begin
        bus3.start = 1'b1;
        bus3.mode = (m == 2'b10) ? 2'b00 : 2'b10;
      end
      if (inject && k == 7) bus3.start = 1'b0;
      @(negedge clk);
    end
    if (bus3.done !== 1'b1) begin n_mis++; $display("FAIL %s done got %b want 1", name, bus3.done); end
    n_cmp++;
    if (bus3.busy !== 1'b0) begin n_mis++; $display("FAIL %s done_busy got %b want 0", name, bus3.busy); end
    n_cmp++;
    if (bus3.pattern !== fin) begin n_mis++; $display("FAIL %s done_pattern got %0d want %0d", name, bus3.pattern, fin); end
    n_cmp++;
    if (bus3.err_cnt !== exp_err) begin n_mis++; $display("FAIL %s err_cnt got %0d want %0d", name, bus3.err_cnt, exp_err); end
    n_cmp++;
    @(negedge clk);
    if (bus3.done !== 1'b0) begin n_mis++; $display("FAIL %s done_width got %b want 0", name, bus3.done); end
    n_cmp++;
    if (bus3.pattern !== fin) begin n_mis++; $display("FAIL %s idle_pattern got %0d want %0d", name, bus3.pattern, fin); end
    n_cmp++;
    if (bus3.err_cnt !== exp_err) begin n_mis++; $display("FAIL %s err_hold got %0d want %0d", name, bus3.err_cnt, exp_err); end
    n_cmp++;
    bus3.mode = 2'b00;
    ideal = 1'b1;
  endtask

  task automatic test_binary();
    sweep3(2'b00, 16, bin_seq, 1'b0, 1'b0, "binary");
  endtask

  task automatic test_walk_and_reserved();
    sweep3(2'b10, 4, walk_seq, 1'b0, 1'b0, "walk");
    sweep3(2'b11, 16, bin_seq, 1'b0, 1'b0, "mode11");
  endtask

  task automatic test_start_ignored();
    sweep3(2'b00, 16, bin_seq, 1'b0, 1'b1, "start_in_run");
    sweep3(2'b10, 4, walk_seq, 1'b0, 1'b1, "mode_in_run");
  endtask

  task automatic test_gray_dwell1();
    logic [3:0] prev;
    prev = '0;
    bus1.mode = 2'b01;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (bus1.pattern !== 4'(gray_seq[k])) begin n_mis++; $display("FAIL gray pattern k=%0d got %0d want %0d", k, bus1.pattern, gray_seq[k]); end
      n_cmp++;
      if (bus1.sample !== 1'b1) begin n_mis++; $display("FAIL gray sample k=%0d got %b want 1", k, bus1.sample); end
      n_cmp++;
      if (k > 0) begin
        if ($countones(bus1.pattern ^ prev) !== 1) begin n_mis++; $display("FAIL gray adjacency k=%0d got %0h after %0h want one-bit step", k, bus1.pattern, prev); end
        n_cmp++;
      end
      prev = bus1.pattern;
      @(negedge clk);
    end
    if (bus1.done !== 1'b1) begin n_mis++; $display("FAIL gray done got %b want 1", bus1.done); end
    n_cmp++;
    if (bus1.pattern !== 4'd8) begin n_mis++; $display("FAIL gray final got %0d want 8", bus1.pattern); end
    n_cmp++;
    @(negedge clk);
    if (bus1.busy !== 1'b0) begin n_mis++; $display("FAIL gray idle_busy got %b want 0", bus1.busy); end
    n_cmp++;
    bus1.mode = 2'b00;
  endtask

  task automatic test_rst_mid();
    bit seen_done;
    bus3.mode = 2'b00;
    bus3.start = 1'b1;
    @(negedge clk);
    bus3.start = 1'b0;
    repeat (15) @(negedge clk);
    if (bus3.pattern !== 4'd5) begin n_mis++; $display("FAIL rst_mid pre_pattern got %0d want 5", bus3.pattern); end
    n_cmp++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    if (bus3.pattern !== 4'd0) begin n_mis++; $display("FAIL rst_mid pattern got %0d want 0", bus3.pattern); end
    n_cmp++;
    if (bus3.busy !== 1'b0) begin n_mis++; $display("FAIL rst_mid busy got %b want 0", bus3.busy); end
    n_cmp++;
    if (bus3.sample !== 1'b0) begin n_mis++; $display("FAIL rst_mid sample got %b want 0", bus3.sample); end
    n_cmp++;
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (bus3.done !== 1'b0 || bus3.busy !== 1'b0) seen_done = 1'b1;
    end
    if (seen_done !== 1'b0) begin n_mis++; $display("FAIL rst_mid activity got %b want 0", seen_done); end
    n_cmp++;
    sweep3(2'b00, 16, bin_seq, 1'b0, 1'b0, "after_rst");
  endtask

  task automatic test_checker();
    sweep3(2'b00, 16, bin_seq, 1'b1, 1'b0, "stuck0");
    sweep3(2'b00, 16, bin_seq, 1'b0, 1'b0, "ideal_or");
  endtask

  task automatic test_back_to_back();
    bus3.mode = 2'b10;
    bus3.start = 1'b1;
    @(negedge clk);
    bus3.start = 1'b0;
    repeat (12) @(negedge clk);
    if (bus3.done !== 1'b1) begin n_mis++; $display("FAIL b2b done got %b want 1", bus3.done); end
    n_cmp++;
    bus3.start = 1'b1;
    @(negedge clk);
    if (bus3.busy !== 1'b0) begin n_mis++; $display("FAIL b2b start_on_done got %b want 0", bus3.busy); end
    n_cmp++;
    @(negedge clk);
    bus3.start = 1'b0;
    if (bus3.busy !== 1'b1) begin n_mis++; $display("FAIL b2b restart_busy got %b want 1", bus3.busy); end
    n_cmp++;
    if (bus3.pattern !== 4'd1) begin n_mis++; $display("FAIL b2b restart_pattern got %0d want 1", bus3.pattern); end
    n_cmp++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus3.mode = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    bus3.start = 1'b0;
    bus3.mode  = 2'b00;
    bus1.start = 1'b0;
    bus1.mode  = 2'b00;
    test_reset();
    test_binary();
    test_gray_dwell1();
    test_walk_and_reserved();
    test_start_ignored();
    test_rst_mid();
    test_checker();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
